// File: rtl/mux8_arb_pkg.sv
// Shared types and sizing helpers for the MUX8 round-robin arbiter.
package mux8_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  // Bits needed to count up to max(hold_min, timeout).
  function automatic int unsigned cnt_width(input int unsigned hold_min,
                                            input int unsigned timeout);
    int unsigned m;
    int unsigned w;
    m = (timeout > hold_min) ? timeout : hold_min;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((m >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping mod 8.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] win;
  logic [SEL_W-1:0] off;

  // Rotating the doubled vector right by ptr puts the search order at bit 0 upward.
  assign win = N_REQ'({req, req} >> ptr);

  always_comb begin
    off = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (win[i-1]) off = SEL_W'(i - 1);
    end
    idx   = ptr + off;
    found = |req;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner sequencer driving the shared MUX8 select, with hold-minimum,
// optional timeout and a one-cycle dead gap between owners.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned HOLD_MIN = 1,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             EN,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic [SEL_W-1:0] SEL,
  output logic             VALID,
  output logic             TOUT
);

  localparam int unsigned CNT_MAX = (TIMEOUT > HOLD_MIN) ? TIMEOUT : HOLD_MIN;
  localparam int unsigned CW      = cnt_width(HOLD_MIN, TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX_V = CW'(CNT_MAX);
  localparam logic [CW-1:0] HOLD_V    = CW'(HOLD_MIN);
  localparam logic [CW-1:0] TOUT_V    = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;

  logic             found;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             rel_normal, rel_forced, release_now, start_grant;

  rr_pick8 u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  assign owner_req   = REQ[sel_q];
  assign rel_normal  = !owner_req && (cnt_q >= HOLD_V);
  assign rel_forced  = (TIMEOUT != 0) && owner_req && (cnt_q == TOUT_V);
  assign release_now = rel_normal || rel_forced;
  assign start_grant = EN && found;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, GAP: state_d = start_grant ? GRANT : IDLE;
      GRANT:     if (release_now) state_d = GAP;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    tout_d  = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, GAP: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        if (start_grant) begin
          gnt_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
          valid_d         = 1'b1;
          cnt_d           = CNT_ONE;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = sel_q + SEL_W'(1);
          tout_d  = rel_forced;
        end else if (cnt_q < CNT_MAX_V) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT   = gnt_q;
  assign SEL   = sel_q;
  assign VALID = valid_q;
  assign TOUT  = tout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed scoreboard bench: instance A (HOLD_MIN=1, no timeout), instance B (HOLD_MIN=4, TIMEOUT=5).
module tb_mux8_rr_arbiter;

  logic       CLK;
  logic       RESETN;
  logic       en_a, en_b;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] sel_a, sel_b;
  logic       valid_a, valid_b, tout_a, tout_b;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned step_no = 0;

  typedef struct {
    bit         dut_b;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       tout;
  } exp_t;

  exp_t sb[$];

  mux8_rr_arbiter #(.HOLD_MIN(1), .TIMEOUT(0)) dut_a (
    .CLK(CLK), .RESETN(RESETN), .EN(en_a), .REQ(req_a),
    .GNT(gnt_a), .SEL(sel_a), .VALID(valid_a), .TOUT(tout_a)
  );

  mux8_rr_arbiter #(.HOLD_MIN(4), .TIMEOUT(5)) dut_b (
    .CLK(CLK), .RESETN(RESETN), .EN(en_b), .REQ(req_b),
    .GNT(gnt_b), .SEL(sel_b), .VALID(valid_b), .TOUT(tout_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
    end
  endtask

  task automatic chk_reset(input bit b);
    chk(b ? "rst_gnt_b" : "rst_gnt_a", b ? gnt_b : gnt_a, 8'h00);
    chk(b ? "rst_sel_b" : "rst_sel_a", {5'd0, b ? sel_b : sel_a}, 8'h00);
    chk(b ? "rst_valid_b" : "rst_valid_a", {7'd0, b ? valid_b : valid_a}, 8'h00);
    chk(b ? "rst_tout_b" : "rst_tout_a", {7'd0, b ? tout_b : tout_a}, 8'h00);
  endtask

  // Inputs are already driven; record what must appear after the next edge.
  task automatic step(input bit b, input logic [7:0] g, input logic [2:0] s,
                      input logic v, input logic t);
    exp_t e;
    e.dut_b = b; e.gnt = g; e.sel = s; e.valid = v; e.tout = t;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    step_no++;
    e = sb.pop_front();
    if (e.dut_b) begin
      chk("gnt_b",   gnt_b,           e.gnt);
      chk("sel_b",   {5'd0, sel_b},   {5'd0, e.sel});
      chk("valid_b", {7'd0, valid_b}, {7'd0, e.valid});
      chk("tout_b",  {7'd0, tout_b},  {7'd0, e.tout});
    end else begin
      chk("gnt_a",   gnt_a,           e.gnt);
      chk("sel_a",   {5'd0, sel_a},   {5'd0, e.sel});
      chk("valid_a", {7'd0, valid_a}, {7'd0, e.valid});
      chk("tout_a",  {7'd0, tout_a},  {7'd0, e.tout});
    end
  endtask

  task automatic pulse_reset();
    RESETN = 1'b0;
    #1;
    chk_reset(1'b0);
    chk_reset(1'b1);
    #1;
    RESETN = 1'b1;
  endtask

  initial begin
    RESETN = 1'b0;
    en_a = 1'b1; en_b = 1'b1;
    req_a = 8'h00; req_b = 8'h00;
    #1;
    chk_reset(1'b0);
    chk_reset(1'b1);
    #1;
    RESETN = 1'b1;

    // Async reset in the middle of an ownership
    req_a = 8'h10; step(0, 8'h10, 3'd4, 1, 0);
    pulse_reset();
    req_a = 8'h01; step(0, 8'h01, 3'd0, 1, 0);
    req_a = 8'h00; step(0, 8'h00, 3'd0, 0, 0);
    step(0, 8'h00, 3'd0, 0, 0);

    // Full round robin, each owner holds two cycles
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      req_a = 8'hFF;             step(0, 8'(1 << k), 3'(k), 1, 0);
      req_a = 8'hFF;             step(0, 8'(1 << k), 3'(k), 1, 0);
      req_a = 8'hFF & ~8'(1 << k); step(0, 8'h00, 3'(k), 0, 0);
    end
    req_a = 8'hFF; step(0, 8'h01, 3'd0, 1, 0);
    req_a = 8'h00; step(0, 8'h00, 3'd0, 0, 0);
    step(0, 8'h00, 3'd0, 0, 0);

    // Wrap from PTR=6
    req_a = 8'h20; step(0, 8'h20, 3'd5, 1, 0);
    req_a = 8'h00; step(0, 8'h00, 3'd5, 0, 0);
    step(0, 8'h00, 3'd5, 0, 0);
    req_a = 8'h83; step(0, 8'h80, 3'd7, 1, 0);
    req_a = 8'h03; step(0, 8'h00, 3'd7, 0, 0);
    req_a = 8'h03; step(0, 8'h01, 3'd0, 1, 0);
    req_a = 8'h02; step(0, 8'h00, 3'd0, 0, 0);
    req_a = 8'h02; step(0, 8'h02, 3'd1, 1, 0);
    req_a = 8'h00; step(0, 8'h00, 3'd1, 0, 0);
    step(0, 8'h00, 3'd1, 0, 0);

    // Enable gating
    en_a = 1'b0; req_a = 8'h04; step(0, 8'h00, 3'd1, 0, 0);
    step(0, 8'h00, 3'd1, 0, 0);
    en_a = 1'b1; step(0, 8'h04, 3'd2, 1, 0);
    en_a = 1'b0; step(0, 8'h04, 3'd2, 1, 0);
    req_a = 8'h08; step(0, 8'h00, 3'd2, 0, 0);
    step(0, 8'h00, 3'd2, 0, 0);
    step(0, 8'h00, 3'd2, 0, 0);
    en_a = 1'b1; req_a = 8'h04; step(0, 8'h04, 3'd2, 1, 0);
    req_a = 8'h00; step(0, 8'h00, 3'd2, 0, 0);
    step(0, 8'h00, 3'd2, 0, 0);

    // Timeout on B: REQ[2] stuck with REQ[5] waiting
    req_b = 8'h24; step(1, 8'h04, 3'd2, 1, 0);
    for (int c = 0; c < 4; c++) step(1, 8'h04, 3'd2, 1, 0);
    step(1, 8'h00, 3'd2, 0, 1);
    step(1, 8'h20, 3'd5, 1, 0);
    req_b = 8'h04;
    for (int c = 0; c < 3; c++) step(1, 8'h20, 3'd5, 1, 0);
    step(1, 8'h00, 3'd5, 0, 0);
    step(1, 8'h04, 3'd2, 1, 0);
    req_b = 8'h00;
    for (int c = 0; c < 3; c++) step(1, 8'h04, 3'd2, 1, 0);
    step(1, 8'h00, 3'd2, 0, 0);
    step(1, 8'h00, 3'd2, 0, 0);

    // Hold minimum on B: one-cycle pulse still owns for four cycles
    req_b = 8'h08; step(1, 8'h08, 3'd3, 1, 0);
    req_b = 8'h00;
    for (int c = 0; c < 3; c++) step(1, 8'h08, 3'd3, 1, 0);
    step(1, 8'h00, 3'd3, 0, 0);
    step(1, 8'h00, 3'd3, 0, 0);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_drain: observed %0d expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
